list_fold_sum: RTL

LIST_FOLD_SUM -- requirements
Module: list_fold_sum

---
 rtl/list_pkg.sv | 17 +
 rtl/list_reader.sv | 55 +++++
 rtl/list_fold_sum.sv | 85 ++++++++
 3 files changed

// File: rtl/list_pkg.sv
// Shared types and defaults for list consumers.
// Provides the fold FSM state enum and default element/accumulator widths.
package list_pkg;

  localparam int LIST_WIDTH = 8;
  localparam int LIST_ACC_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CHECK,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } list_state_e;

endpackage

// File: rtl/list_reader.sv
// List producer handshake: ARM/CHECK/REQ/WAIT sequencing.
// Ports: clock, reset, ready, list_ack, list_eol in; list_ready, list_req,
// idle, elem_valid (accepted ack strobe), elem_end (end seen in CHECK) out.
module list_reader
  import list_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic ready,
  input  logic list_ack,
  input  logic list_eol,
  output logic list_ready,
  output logic list_req,
  output logic idle,
  output logic elem_valid,
  output logic elem_end
);

  list_state_e state_q;
  list_state_e state_d;

  always_comb begin
    state_d = state_q;
    if (!ready) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_ARM;
        ST_ARM:   state_d = ST_CHECK;
        ST_CHECK: state_d = list_eol ? ST_DONE : ST_REQ;
        ST_REQ:   state_d = ST_WAIT;
        ST_WAIT:  state_d = list_ack ? ST_CHECK : ST_WAIT;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode the registered state only, so list_req is a clean
  // one-cycle pulse and eol is looked at only once the producer settled.
  assign idle       = (state_q == ST_IDLE);
  assign list_ready = (state_q != ST_IDLE);
  assign list_req   = (state_q == ST_REQ);
  assign elem_valid = (state_q == ST_WAIT) && list_ack;
  assign elem_end   = (state_q == ST_CHECK) && list_eol;

endmodule

// File: rtl/list_fold_sum.sv
// Folds a producer list into a signed wrapping sum; macro LIST_FOLD_COUNT_EN
// adds count. Ports: clock, reset, ready, list_ack/eol/value in; done, result,
// list_ready, list_req (and count) out.
module list_fold_sum
  import list_pkg::*;
#(
  parameter int WIDTH = LIST_WIDTH,
  parameter int ACC_W = LIST_ACC_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ready,
  output logic                    done,
  output logic signed [ACC_W-1:0] result,
  output logic                    list_ready,
  output logic                    list_req,
  input  logic                    list_ack,
  input  logic                    list_eol,
  input  logic signed [WIDTH-1:0] list_value
`ifdef LIST_FOLD_COUNT_EN
  ,
  output logic [ACC_W-1:0]        count
`endif
);

  logic                    idle;
  logic                    elem_valid;
  logic                    elem_end;
  logic [ACC_W-1:0]        acc_q;
  logic                    done_q;
  logic signed [ACC_W-1:0] ext;

  list_reader u_reader (
    .clock      (clock),
    .reset      (reset),
    .ready      (ready),
    .list_ack   (list_ack),
    .list_eol   (list_eol),
    .list_ready (list_ready),
    .list_req   (list_req),
    .idle       (idle),
    .elem_valid (elem_valid),
    .elem_end   (elem_end)
  );

  assign ext = ACC_W'(list_value);

  // Dropping ready (or sitting idle) throws away any partial sum.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      done_q <= 1'b0;
    end else if (!ready || idle) begin
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (elem_valid) begin
        acc_q <= acc_q + ext;
      end
      if (elem_end) begin
        done_q <= 1'b1;
      end
    end
  end

  assign result = acc_q;
  assign done   = done_q;

`ifdef LIST_FOLD_COUNT_EN
  logic [ACC_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!ready || idle) begin
      cnt_q <= '0;
    end else if (elem_valid) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = cnt_q;
`endif

endmodule
